// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the writeback arbiter
//   NUM_WR  - register file write ports
//   PREG_W  - physical register tag width
//   DATA_W  - result data width
package wb_pkg;
    localparam int NUM_WR = 4;
    localparam int PREG_W = 5;
    localparam int DATA_W = 16;
    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef struct packed {
        preg_t preg;
        data_t data;
    } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: result-source and register-file-write bundle of the writeback arbiter
//   src_valid/src_ready/src_preg/src_data - per-source result handshake
//   flush                                 - synchronous drop of all buffered results
//   reg_wr_en/reg_wr_addr/reg_wr_data     - registered register file write ports
//   busy                                  - any source FIFO non-empty
//   master: drives sources and flush; slave: the arbiter
interface wb_arbiter_if import wb_pkg::*; #(parameter int NUM_SRC = 6);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    preg_t [NUM_SRC-1:0]       src_preg;
    data_t [NUM_SRC-1:0]       src_data;
    logic                      flush;
    logic [NUM_WR-1:0]         reg_wr_en;
    preg_t [NUM_WR-1:0]        reg_wr_addr;
    data_t [NUM_WR-1:0]        reg_wr_data;
    logic                      busy;
    modport master (
        output src_valid, src_preg, src_data, flush,
        input  src_ready, reg_wr_en, reg_wr_addr, reg_wr_data, busy
    );
    modport slave (
        input  src_valid, src_preg, src_data, flush,
        output src_ready, reg_wr_en, reg_wr_addr, reg_wr_data, busy
    );
endinterface

// File: rtl/wb_src_fifo.sv
// wb_src_fifo: per-source circular result buffer
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_flush     - synchronous empty
//   i_valid     - source offers i_entry (accepted when o_ready)
//   i_deq       - pop head (ignored when empty)
//   o_ready     - count < DEPTH, from registered state only
//   o_nonempty  - head is valid
//   o_head      - oldest entry
module wb_src_fifo import wb_pkg::*; #(parameter int DEPTH = 2) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_flush,
    input  logic      i_valid,
    input  wb_entry_t i_entry,
    input  logic      i_deq,
    output logic      o_ready,
    output logic      o_nonempty,
    output wb_entry_t o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    wb_entry_t      r_mem [DEPTH];
    logic [AW-1:0]  r_rd, r_wr;
    logic [AW:0]    r_cnt;
    logic           w_enq, w_deq;
    // a full FIFO refuses even when popping this cycle: no passthrough
    assign o_ready    = r_cnt != FULL;
    assign o_nonempty = r_cnt != '0;
    assign o_head     = r_mem[r_rd];
    assign w_enq      = i_valid & o_ready;
    assign w_deq      = i_deq & o_nonempty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_enq) r_wr <= r_wr + 1'b1;
            if (w_deq) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_enq) - (AW+1)'(w_deq);
        end
    end
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr] <= i_entry;
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter feeding NUM_WR register file write ports
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of wb_arbiter_if (sources, flush, write ports, busy)
module wb_arbiter import wb_pkg::*; #(
    parameter int NUM_SRC = 6,
    parameter int DEPTH   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    localparam int RR_W = $clog2(NUM_SRC);
    localparam int SW   = $clog2(NUM_WR);
    localparam logic [RR_W:0] NSRC = (RR_W+1)'(NUM_SRC);
    localparam logic [SW:0]   NWR  = (SW+1)'(NUM_WR);
    localparam logic [RR_W-1:0] LAST = RR_W'(NUM_SRC - 1);
    wb_entry_t [NUM_SRC-1:0] w_head;
    logic [NUM_SRC-1:0]      w_nonempty, w_ready, w_grant;
    logic [NUM_WR-1:0]       w_en, r_en;
    preg_t [NUM_WR-1:0]      w_addr, r_addr;
    data_t [NUM_WR-1:0]      w_data, r_data;
    logic [RR_W-1:0]         r_rr, w_rr_nxt;
    logic                    w_any;
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_flush    (bus.flush),
            .i_valid    (bus.src_valid[g]),
            .i_entry    (wb_entry_t'({bus.src_preg[g], bus.src_data[g]})),
            .i_deq      (w_grant[g]),
            .o_ready    (w_ready[g]),
            .o_nonempty (w_nonempty[g]),
            .o_head     (w_head[g])
        );
    end
    // scan from r_rr, packing grants densely into slots; a head whose preg
    // matches an earlier grant this cycle is deferred to keep writes unique
    always_comb begin
        logic [RR_W:0]   t;
        logic [RR_W-1:0] s, l;
        logic [SW:0]     n;
        logic            hit;
        w_grant = '0;
        w_en    = '0;
        w_addr  = '0;
        w_data  = '0;
        n       = '0;
        l       = r_rr;
        for (int j = 0; j < NUM_SRC; j++) begin
            t = {1'b0, r_rr} + (RR_W+1)'(j);
            s = (t >= NSRC) ? RR_W'(t - NSRC) : t[RR_W-1:0];
            hit = 1'b0;
            for (int k = 0; k < NUM_WR; k++) begin
                if ((SW+1)'(k) < n && w_addr[k] == w_head[s].preg) hit = 1'b1;
            end
            if (w_nonempty[s] && !hit && n < NWR) begin
                w_grant[s]         = 1'b1;
                w_en[n[SW-1:0]]    = 1'b1;
                w_addr[n[SW-1:0]]  = w_head[s].preg;
                w_data[n[SW-1:0]]  = w_head[s].data;
                l                  = s;
                n                  = n + 1'b1;
            end
        end
        w_any    = n != '0;
        w_rr_nxt = !w_any ? r_rr : (l == LAST) ? '0 : l + 1'b1;
    end
    // addr/data of idle slots keep their last value; only enables drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en   <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_rr   <= '0;
        end else if (bus.flush) begin
            r_en <= '0;
            r_rr <= '0;
        end else begin
            r_en <= w_en;
            r_rr <= w_rr_nxt;
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_en[k]) begin
                    r_addr[k] <= w_addr[k];
                    r_data[k] <= w_data[k];
                end
            end
        end
    end
    assign bus.src_ready   = w_ready;
    assign bus.busy        = |w_nonempty;
    assign bus.reg_wr_en   = r_en;
    assign bus.reg_wr_addr = r_addr;
    assign bus.reg_wr_data = r_data;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scoreboard bench for wb_arbiter
module tb_wb_arbiter;
    typedef struct {
        int slot;
        int preg;
        int data;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    wb_arbiter_if #(.NUM_SRC(6)) bus();
    wb_arbiter #(.NUM_SRC(6), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input int s, input int p, input int d);
        q.push_back('{s, p, d});
    endtask
    task automatic offer(input int i, input int p, input int d);
        bus.src_valid[i] = 1'b1;
        bus.src_preg[i]  = 5'(p);
        bus.src_data[i]  = 16'(d);
    endtask
    // monitor: every asserted write enable consumes one expected write
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.reg_wr_en[k]) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write: slot %0d preg %0d data %0h, none expected",
                                 k, bus.reg_wr_addr[k], bus.reg_wr_data[k]);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        if (e.slot != k || e.preg != int'(bus.reg_wr_addr[k]) ||
                            e.data != int'(bus.reg_wr_data[k])) begin
                            failures++;
                            $display("FAIL write: got slot %0d preg %0d data %0h expected slot %0d preg %0d data %0h",
                                     k, bus.reg_wr_addr[k], bus.reg_wr_data[k], e.slot, e.preg, e.data);
                        end
                    end
                end
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.src_valid = '0;
        bus.src_preg  = '0;
        bus.src_data  = '0;
        bus.flush     = 1'b0;
        #12;
        chk("rst_en", int'(bus.reg_wr_en), 0);
        chk("rst_addr0", int'(bus.reg_wr_addr[0]), 0);
        chk("rst_data0", int'(bus.reg_wr_data[0]), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", int'(bus.src_ready), 'h3F);
        // single result, minimum latency
        offer(0, 3, 'hBEEF);
        push(0, 3, 'hBEEF);
        tick();
        bus.src_valid = '0;
        chk("t1_busy_c2", int'(bus.busy), 1);
        chk("t1_en_c2", int'(bus.reg_wr_en), 0);
        tick();
        chk("t1_en_c3", int'(bus.reg_wr_en), 1);
        chk("t1_busy_c3", int'(bus.busy), 0);
        tick();
        chk("t1_en_c4", int'(bus.reg_wr_en), 0);
        // flush returns rr_ptr to 0; then six distinct pregs at once
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t2_ready", int'(bus.src_ready), 'h3F);
        for (int i = 0; i < 6; i++) offer(i, i + 1, 'h100 + i);
        for (int i = 0; i < 4; i++) push(i, i + 1, 'h100 + i);
        push(0, 5, 'h104);
        push(1, 6, 'h105);
        tick();
        bus.src_valid = '0;
        tick();
        chk("t2_en_full", int'(bus.reg_wr_en), 'hF);
        tick();
        chk("t2_en_rest", int'(bus.reg_wr_en), 'h3);
        tick();
        chk("t2_en_idle", int'(bus.reg_wr_en), 0);
        // preg conflict: rr_ptr is back at 0, src0 wins first
        offer(0, 9, 'h0001);
        offer(1, 9, 'h0002);
        push(0, 9, 'h0001);
        push(0, 9, 'h0002);
        tick();
        bus.src_valid = '0;
        tick();
        chk("t3_en_first", int'(bus.reg_wr_en), 1);
        tick();
        chk("t3_en_second", int'(bus.reg_wr_en), 1);
        tick();
        chk("t3_en_idle", int'(bus.reg_wr_en), 0);
        // backpressure on src2 behind same-preg heads of src0/src1
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        offer(0, 7, 'hA000);
        offer(1, 7, 'hB000);
        offer(2, 7, 'h2000);
        push(0, 7, 'hA000);
        push(0, 7, 'hB000);
        push(0, 7, 'h2000);
        push(0, 7, 'h2001);
        push(0, 7, 'h2002);
        tick();
        bus.src_valid[0] = 1'b0;
        bus.src_valid[1] = 1'b0;
        bus.src_data[2]  = 16'h2001;
        chk("t4_ready_1", int'(bus.src_ready[2]), 1);
        tick();
        bus.src_data[2] = 16'h2002;
        chk("t4_ready_full", int'(bus.src_ready[2]), 0);
        tick();
        chk("t4_ready_held", int'(bus.src_ready[2]), 0);
        tick();
        chk("t4_ready_free", int'(bus.src_ready[2]), 1);
        tick();
        bus.src_valid = '0;
        chk("t4_ready_after", int'(bus.src_ready[2]), 1);
        tick();
        chk("t4_busy_done", int'(bus.busy), 0);
        tick();
        chk("t4_en_idle", int'(bus.reg_wr_en), 0);
        // fill every FIFO with one shared preg, then flush
        for (int i = 0; i < 6; i++) offer(i, 12, 'hF0 + i);
        tick();
        for (int i = 0; i < 6; i++) bus.src_data[i] = 16'('hE0 + i);
        chk("t5_ready_half", int'(bus.src_ready), 'h3F);
        chk("t5_busy", int'(bus.busy), 1);
        push(0, 12, 'hF3);
        tick();
        chk("t5_ready_full", int'(bus.src_ready), 'h08);
        bus.src_valid = '0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t5_en_flush", int'(bus.reg_wr_en), 0);
        chk("t5_busy_flush", int'(bus.busy), 0);
        chk("t5_ready_flush", int'(bus.src_ready), 'h3F);
        tick();
        chk("t5_en_quiet1", int'(bus.reg_wr_en), 0);
        tick();
        chk("t5_en_quiet2", int'(bus.reg_wr_en), 0);
        // asynchronous reset while all four ports write
        for (int i = 0; i < 6; i++) offer(i, 20 + i, 'h600 + i);
        for (int i = 0; i < 4; i++) push(i, 20 + i, 'h600 + i);
        tick();
        bus.src_valid = '0;
        tick();
        chk("t6_en_full", int'(bus.reg_wr_en), 'hF);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_en_async", int'(bus.reg_wr_en), 0);
        chk("t6_busy_async", int'(bus.busy), 0);
        chk("t6_ready_async", int'(bus.src_ready), 'h3F);
        #1;
        rst_n = 1'b1;
        offer(4, 30, 'h1234);
        push(0, 30, 'h1234);
        tick();
        bus.src_valid = '0;
        tick();
        chk("t6_en_post", int'(bus.reg_wr_en), 1);
        tick();
        chk("t6_en_idle", int'(bus.reg_wr_en), 0);
        tick();
        chk("pending_writes", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter directly upstream of the 4W/8R physical register file (32 x 16b).
- Accepts results from NUM_SRC functional-unit result ports, each with a valid/ready handshake, and buffers them in small per-source FIFOs.
- Each cycle it grants up to NUM_WR results round-robin and drives the register file write ports from registered outputs.

Parameters:
- NUM_SRC, 6, number of functional-unit result sources.
- DEPTH, 2, entries per source FIFO (power of two, >= 2).
- NUM_WR, 4, register file write ports.
- PREG_W, 5, physical register tag width.
- DATA_W, 16, result data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; drops all buffered results.
- src_valid  in  [NUM_SRC]  result valid, per source.
- src_ready  out  [NUM_SRC]  source FIFO can accept.
- src_preg  in  [NUM_SRC][PREG_W]  destination physical register.
- src_data  in  [NUM_SRC][DATA_W]  result value.
- reg_wr_en  out  [NUM_WR]  write enable per port.
- reg_wr_addr  out  [NUM_WR][PREG_W]  write address per port.
- reg_wr_data  out  [NUM_WR][DATA_W]  write data per port.
- busy  out  1  any FIFO non-empty.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, all FIFOs empty, rr_ptr=0, src_ready=all 1 once rst_n deasserts, busy=0.
- Handshake:
  - Accept occurs when src_valid[i] and src_ready[i] are both high at a rising edge.
  - src_ready[i] = (count[i] < DEPTH), computed from registered state only. There is no combinational path from src_valid to src_ready.
  - A full FIFO deasserts ready even if it dequeues in the same cycle; there is no full-FIFO passthrough.
  - Data, preg and valid must be held while valid is high and ready is low.
- FIFO: per-source circular buffer with wrapping rd/wr pointers and a count of 0..DEPTH. Enqueue and dequeue may occur in the same cycle; count is then unchanged.
- Arbitration (combinational, on FIFO heads, each cycle):
  - Scan sources in order rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - Grant each non-empty head into the next free slot 0..NUM_WR-1, in scan order.
  - Preg conflict: skip a head whose preg equals a preg already granted this cycle. It stays queued for a later cycle.
  - Stop when NUM_WR slots are filled or the scan completes.
  - Granted FIFOs dequeue at the clock edge.
- rr_ptr update: if at least one grant, rr_ptr <= (index of last granted source + 1) mod NUM_SRC; otherwise rr_ptr is unchanged.
- Output registers:
  - reg_wr_en[k] <= slot k granted.
  - reg_wr_addr[k] and reg_wr_data[k] <= the granted head. When slot k is not granted, addr/data hold their previous values and en=0.
  - Slots fill densely from 0; no holes.
- Latency: a result accepted at edge t is visible at its FIFO head in cycle t+1. If granted in cycle t+1, reg_wr_en is high during cycle t+2. Minimum latency is 2 cycles. Peak throughput is NUM_WR writes per cycle.
- Fairness: any non-empty head is granted within ceil(NUM_SRC/NUM_WR)+1 cycles, excluding preg-conflict deferrals.
- flush:
  - At the edge: all FIFOs are emptied, reg_wr_en <= 0, rr_ptr <= 0.
  - Source accepts in the flush cycle are discarded.
  - src_ready is all 1 in the following cycle.
- busy = OR of (count[i] != 0) over all sources.
- Reset mid-operation: all state clears immediately (asynchronous reset), buffered results are lost, and reg_wr_en drops at once.
- Preg 0 gets no special treatment.

Decomposition:
- Shared package wb_pkg:
  - Constants: NUM_WR, PREG_W, DATA_W.
  - Typedefs: preg_t (logic [PREG_W-1:0]), data_t (logic [DATA_W-1:0]), wb_entry_t (struct of preg_t preg and data_t data).
- Sub-module wb_src_fifo: one per source, parameterised by DEPTH; single-entry enqueue/dequeue with count, ready and head outputs.
- Arbiter and output registers live in wb_arbiter.

Test Plan:
- Reset, then src0 offers preg=3, data=0xBEEF at cycle 1 -> reg_wr_en=4'b0001, addr[0]=3, data[0]=0xBEEF in cycle 3; busy high in cycle 2 only.
- All 6 sources offer pregs 1..6 in the same cycle with rr_ptr=0 -> next-next cycle en=1111 carrying pregs 1,2,3,4; following cycle en=0011 carrying pregs 5,6; rr_ptr ends at 0.
- Sources 0 and 1 both target preg 9 (data 0x0001, 0x0002) -> slot0 writes 0x0001; one cycle later slot0 writes 0x0002; no cycle has two enables to preg 9.
- Source 2 sends back-to-back with no dequeue (all sources saturated) -> ready falls after 2 accepts; src_valid held high with ready low has no effect; the third item is accepted only after a dequeue.
- Fill FIFOs, assert flush for 1 cycle -> next cycle en=0, busy=0, all ready=1, and no flushed value is ever written.
- Assert rst_n=0 asynchronously mid-cycle while en=1111 -> en=0 immediately, before the next clk edge; after release the first write matches the first post-reset accept.
